mcu_tx_scheduler: RTL

- Shares the single MCU UART transmitter between several message sources: PTT/RX state, band change, fault report and a periodic keep-alive.
- Latches one-cycle requests from up to NUM_REQ channels and grants them by fixed priority.
- Drives the UART_TX byte handshake, one byte at a time, with a watchdog on each transfer.
- Sits between the radio control logic and UART_TX inside the mcu block, in the 122.88 MHz domain.

---
 rtl/mcu_tx_scheduler_if.sv | 10 +
 rtl/mcu_tx_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mcu_tx_scheduler_if.sv
// Byte handshake between the MCU transmit scheduler and UART_TX.
interface mcu_tx_scheduler_if;
   logic       tx_dv;
   logic [7:0] tx_byte;
   logic       tx_active;
   logic       tx_done;

   modport master (output tx_dv, output tx_byte, input tx_active, input tx_done);
   modport slave  (input tx_dv, input tx_byte, output tx_active, output tx_done);
endinterface

// File: rtl/mcu_tx_scheduler.sv
// Shares one UART_TX between fixed-priority request channels and a periodic
// keep-alive byte, with a per-transfer watchdog.
module mcu_tx_scheduler #(
   parameter int         NUM_REQ          = 4,
   parameter int         HEARTBEAT_CYCLES = 122880000,
   parameter logic [7:0] HEARTBEAT_BYTE   = 8'h25,
   parameter int         TIMEOUT_CYCLES   = 131072
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] chan_byte,
   mcu_tx_scheduler_if.master   uart,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   sent,
   output logic                 hb_sent,
   output logic                 busy,
   output logic                 err_timeout,
   input  logic                 err_clr
);

   localparam int HB_W = (HEARTBEAT_CYCLES > 0) ? $clog2(HEARTBEAT_CYCLES + 1) : 1;
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit              HB_EN   = (HEARTBEAT_CYCLES != 0);
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  pending_q, pending_d;
   logic                tx_dv_q, tx_dv_d;
   logic [7:0]          tx_byte_q, tx_byte_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  sent_q, sent_d;
   logic                hb_sent_q, hb_sent_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic [HB_W-1:0]     hb_cnt_q, hb_cnt_d;
   logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
   logic [NUM_REQ-1:0]  cur_oh_q, cur_oh_d;   // all-zero marks a keep-alive transfer

   logic [NUM_REQ-1:0]  pick_oh_s;
   logic [NUM_REQ-1:0]  clr_s;
   logic [7:0]          pick_byte_s;
   logic                err_set_s;

   // lowest set bit of pending is the winning channel
   assign pick_oh_s = pending_q & (~pending_q + NUM_REQ'(1));

   // next-state, arbitration, watchdog and keep-alive timing
   always_comb begin
      state_d     = state_q;
      tx_dv_d     = 1'b0;
      tx_byte_d   = tx_byte_q;
      grant_d     = '0;
      sent_d      = '0;
      hb_sent_d   = 1'b0;
      hb_cnt_d    = hb_cnt_q;
      wd_cnt_d    = wd_cnt_q;
      cur_oh_d    = cur_oh_q;
      clr_s       = '0;
      err_set_s   = 1'b0;
      pick_byte_s = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         pick_byte_s = pick_byte_s | (chan_byte[8*k +: 8] & {8{pick_oh_s[k]}});
      end

      case (state_q)
         IDLE: begin
            if (pending_q != '0) begin
               tx_byte_d = pick_byte_s;
               tx_dv_d   = 1'b1;
               grant_d   = pick_oh_s;
               clr_s     = pick_oh_s;
               cur_oh_d  = pick_oh_s;
               wd_cnt_d  = '0;
               hb_cnt_d  = '0;
               state_d   = START;
            end else if (HB_EN && (hb_cnt_q == HB_LAST)) begin
               tx_byte_d = HEARTBEAT_BYTE;
               tx_dv_d   = 1'b1;
               cur_oh_d  = '0;
               wd_cnt_d  = '0;
               hb_cnt_d  = '0;
               state_d   = START;
            end else if (HB_EN) begin
               hb_cnt_d = hb_cnt_q + HB_W'(1);
            end else begin
               hb_cnt_d = '0;
            end
         end
         START: begin
            if (wd_cnt_q == WD_LAST) begin
               err_set_s = 1'b1;
               state_d   = GAP;
            end else begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
               if (uart.tx_active) begin
                  state_d = WAIT_DONE;
               end else begin
                  state_d = START;
               end
            end
         end
         WAIT_DONE: begin
            if (wd_cnt_q == WD_LAST) begin
               err_set_s = 1'b1;
               state_d   = GAP;
            end else begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
               if (uart.tx_done) begin
                  sent_d    = cur_oh_q;
                  hb_sent_d = (cur_oh_q == '0);
                  state_d   = GAP;
               end else begin
                  state_d = WAIT_DONE;
               end
            end
         end
         GAP: begin
            // wait for UART_TX to be fully idle so the next tx_dv is not lost
            if (!uart.tx_done && !uart.tx_active) begin
               state_d = IDLE;
            end else begin
               state_d = GAP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      pending_d = (pending_q & ~clr_s) | req;
      err_d     = err_set_s | (err_q & ~err_clr);
      busy_d    = (state_d != IDLE);
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_q   <= IDLE;
         pending_q <= '0;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= 8'h00;
         grant_q   <= '0;
         sent_q    <= '0;
         hb_sent_q <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         hb_cnt_q  <= '0;
         wd_cnt_q  <= '0;
         cur_oh_q  <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         tx_dv_q   <= tx_dv_d;
         tx_byte_q <= tx_byte_d;
         grant_q   <= grant_d;
         sent_q    <= sent_d;
         hb_sent_q <= hb_sent_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         hb_cnt_q  <= hb_cnt_d;
         wd_cnt_q  <= wd_cnt_d;
         cur_oh_q  <= cur_oh_d;
      end
   end

   assign uart.tx_dv   = tx_dv_q;
   assign uart.tx_byte = tx_byte_q;
   assign grant        = grant_q;
   assign sent         = sent_q;
   assign hb_sent      = hb_sent_q;
   assign busy         = busy_q;
   assign err_timeout  = err_q;

endmodule
